// File: rtl/pic_pkg.sv
// Shared types and constants for the 8259 host-side bus master.
// ICW sequencing helper lives here so the top stays focused on timing.
package pic_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SETUP,
        ST_STROBE,
        ST_HOLD,
        ST_INTA_LOW,
        ST_INTA_GAP,
        ST_FINISH
    } state_t;

    typedef enum logic [1:0] {
        OP_INIT,
        OP_OCW,
        OP_READ,
        OP_INTA
    } op_t;

    localparam int ICW1_IC4  = 0;
    localparam int ICW1_SNGL = 1;
    localparam int ICW1_INIT = 4;

    localparam logic A0_CMD  = 1'b0;
    localparam logic A0_DATA = 1'b1;

    // Returns {more, nextIdx}: the next ICW that is actually sent after idx.
    function automatic logic [2:0] nextIcw(input logic [1:0] idx, input logic sngl,
                                           input logic ic4);
        logic [2:0] sel;
        sel = 3'b000;
        case (idx)
            2'd0: sel = {1'b1, 2'd1};
            2'd1: begin
                if (!sngl) begin
                    sel = {1'b1, 2'd2};
                end else if (ic4) begin
                    sel = {1'b1, 2'd3};
                end
            end
            2'd2: if (ic4) sel = {1'b1, 2'd3};
            default: sel = 3'b000;
        endcase
        return sel;
    endfunction

endpackage

// File: rtl/pic_bus_phase_timer.sv
// Loadable 4-bit down-counter; expired_o is high once the count reaches zero.
// A phase of N clocks is timed by loading N-1 on the phase entry edge.
module pic_bus_phase_timer (
    input  logic       clk,
    input  logic       rst,
    input  logic       load_i,
    input  logic [3:0] loadVal_i,
    output logic       expired_o
);

    logic [3:0] count_q, count_d;

    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = loadVal_i;
        end else if (count_q != 4'd0) begin
            count_d = count_q - 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q <= 4'd0;
        end else begin
            count_q <= count_d;
        end
    end

    assign expired_o = (count_q == 4'd0);

endmodule

// File: rtl/pic_bus_master.sv
// CPU-side initiator for the 8259 host interface: ICW init sequences, OCW
// writes, status reads and the INTA acknowledge cycle with vector capture.
module pic_bus_master
    import pic_pkg::*;
#(
    parameter int unsigned SETUP_CYC  = 1,
    parameter int unsigned STROBE_CYC = 2,
    parameter int unsigned HOLD_CYC   = 1,
    parameter int unsigned NUM_INTA   = 2,
    parameter int unsigned INTA_GAP   = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       init_req,
    input  logic [7:0] icw1,
    input  logic [7:0] icw2,
    input  logic [7:0] icw3,
    input  logic [7:0] icw4,
    input  logic       ocw_req,
    input  logic       ocw_a0,
    input  logic [7:0] ocw_data,
    input  logic       rd_req,
    input  logic       rd_a0,
    input  logic       int_in,
    output logic       busy,
    output logic       done,
    output logic [7:0] rd_data,
    output logic       vector_valid,
    output logic [7:0] vector,
    output logic       WR_n,
    output logic       RD_n,
    output logic       INTA_n,
    output logic       A0,
    output logic [7:0] data_out,
    output logic       data_oe,
    input  logic [7:0] data_in
);

    localparam logic [3:0] SETUP_LD  = 4'(SETUP_CYC - 1);
    localparam logic [3:0] STROBE_LD = 4'(STROBE_CYC - 1);
    localparam logic [3:0] HOLD_LD   = 4'(HOLD_CYC - 1);
    localparam logic [3:0] GAP_LD    = 4'(INTA_GAP - 1);
    localparam logic [1:0] INTA_LAST = 2'(NUM_INTA - 1);

    state_t     state_q, state_d;
    op_t        op_q, op_d;
    logic [1:0] icwIdx_q, icwIdx_d;
    logic [1:0] intaCnt_q, intaCnt_d;
    logic       a0_q, a0_d;
    logic [7:0] dout_q, dout_d;
    logic       sngl_q, ic4_q;
    logic [7:0] icw2_q, icw3_q, icw4_q;
    logic [7:0] rdData_q, vector_q;

    logic       timerLoad;
    logic [3:0] timerVal;
    logic       timerExp;
    logic [2:0] nextSel;
    logic [7:0] icw1Forced;
    logic       accInit;
    logic       isWrite;

    pic_bus_phase_timer u_timer (
        .clk      (clk),
        .rst      (rst),
        .load_i   (timerLoad),
        .loadVal_i(timerVal),
        .expired_o(timerExp)
    );

    assign accInit = (state_q == ST_IDLE) && init_req;
    assign nextSel = nextIcw(icwIdx_q, sngl_q, ic4_q);

    always_comb begin
        icw1Forced            = icw1;
        icw1Forced[ICW1_INIT] = 1'b1;
    end

    // Next-state logic; the bus A0/data registers are reloaded on every SETUP entry.
    always_comb begin
        state_d   = state_q;
        op_d      = op_q;
        icwIdx_d  = icwIdx_q;
        intaCnt_d = intaCnt_q;
        a0_d      = a0_q;
        dout_d    = dout_q;
        timerLoad = 1'b0;
        timerVal  = 4'd0;
        unique case (state_q)
            ST_IDLE: begin
                if (init_req) begin
                    state_d   = ST_SETUP;
                    op_d      = OP_INIT;
                    icwIdx_d  = 2'd0;
                    a0_d      = A0_CMD;
                    dout_d    = icw1Forced;
                    timerLoad = 1'b1;
                    timerVal  = SETUP_LD;
                end else if (ocw_req) begin
                    state_d   = ST_SETUP;
                    op_d      = OP_OCW;
                    a0_d      = ocw_a0;
                    dout_d    = ocw_data;
                    timerLoad = 1'b1;
                    timerVal  = SETUP_LD;
                end else if (rd_req) begin
                    state_d   = ST_SETUP;
                    op_d      = OP_READ;
                    a0_d      = rd_a0;
                    timerLoad = 1'b1;
                    timerVal  = SETUP_LD;
                end else if (int_in) begin
                    state_d   = ST_INTA_LOW;
                    op_d      = OP_INTA;
                    intaCnt_d = 2'd0;
                    timerLoad = 1'b1;
                    timerVal  = STROBE_LD;
                end
            end
            ST_SETUP: begin
                if (timerExp) begin
                    state_d   = ST_STROBE;
                    timerLoad = 1'b1;
                    timerVal  = STROBE_LD;
                end
            end
            ST_STROBE: begin
                if (timerExp) begin
                    state_d   = ST_HOLD;
                    timerLoad = 1'b1;
                    timerVal  = HOLD_LD;
                end
            end
            ST_HOLD: begin
                if (timerExp) begin
                    if (op_q == OP_INIT && nextSel[2]) begin
                        state_d   = ST_SETUP;
                        icwIdx_d  = nextSel[1:0];
                        a0_d      = A0_DATA;
                        timerLoad = 1'b1;
                        timerVal  = SETUP_LD;
                        case (nextSel[1:0])
                            2'd2:    dout_d = icw3_q;
                            2'd3:    dout_d = icw4_q;
                            default: dout_d = icw2_q;
                        endcase
                    end else begin
                        state_d = ST_FINISH;
                    end
                end
            end
            ST_INTA_LOW: begin
                if (timerExp) begin
                    if (intaCnt_q == INTA_LAST) begin
                        state_d = ST_FINISH;
                    end else begin
                        state_d   = ST_INTA_GAP;
                        intaCnt_d = intaCnt_q + 2'd1;
                        timerLoad = 1'b1;
                        timerVal  = GAP_LD;
                    end
                end
            end
            ST_INTA_GAP: begin
                if (timerExp) begin
                    state_d   = ST_INTA_LOW;
                    timerLoad = 1'b1;
                    timerVal  = STROBE_LD;
                end
            end
            ST_FINISH: state_d = ST_IDLE;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Read data and vector are captured on the last low clock of their strobe.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_IDLE;
            op_q      <= OP_INIT;
            icwIdx_q  <= 2'd0;
            intaCnt_q <= 2'd0;
            a0_q      <= 1'b0;
            dout_q    <= 8'h00;
            sngl_q    <= 1'b0;
            ic4_q     <= 1'b0;
            icw2_q    <= 8'h00;
            icw3_q    <= 8'h00;
            icw4_q    <= 8'h00;
            rdData_q  <= 8'h00;
            vector_q  <= 8'h00;
        end else begin
            state_q   <= state_d;
            op_q      <= op_d;
            icwIdx_q  <= icwIdx_d;
            intaCnt_q <= intaCnt_d;
            a0_q      <= a0_d;
            dout_q    <= dout_d;
            if (accInit) begin
                sngl_q <= icw1[ICW1_SNGL];
                ic4_q  <= icw1[ICW1_IC4];
                icw2_q <= icw2;
                icw3_q <= icw3;
                icw4_q <= icw4;
            end
            if (state_q == ST_STROBE && timerExp && op_q == OP_READ) begin
                rdData_q <= data_in;
            end
            if (state_q == ST_INTA_LOW && timerExp && intaCnt_q == INTA_LAST) begin
                vector_q <= data_in;
            end
        end
    end

    assign isWrite      = (op_q == OP_INIT) || (op_q == OP_OCW);
    assign busy         = (state_q != ST_IDLE) && (state_q != ST_FINISH);
    assign done         = (state_q == ST_FINISH) && (op_q != OP_INTA);
    assign vector_valid = (state_q == ST_FINISH) && (op_q == OP_INTA);
    assign WR_n         = !((state_q == ST_STROBE) && isWrite);
    assign RD_n         = !((state_q == ST_STROBE) && (op_q == OP_READ));
    assign INTA_n       = (state_q != ST_INTA_LOW);
    assign data_oe      = isWrite && ((state_q == ST_SETUP) || (state_q == ST_STROBE) ||
                                      (state_q == ST_HOLD));
    assign A0           = a0_q;
    assign data_out     = dout_q;
    assign rd_data      = rdData_q;
    assign vector       = vector_q;

endmodule

// File: tb/tb_pic_bus_master.sv
// Self-checking bench for pic_bus_master: a negedge monitor records every bus
// strobe into obsQ and each test compares it against the events it expects.
module tb_pic_bus_master;

    logic       clk = 1'b0;
    logic       rst;
    logic       init_req, ocw_req, rd_req, int_in;
    logic [7:0] icw1, icw2, icw3, icw4;
    logic       ocw_a0, rd_a0;
    logic [7:0] ocw_data, data_in;
    logic       busy, done, vector_valid, WR_n, RD_n, INTA_n, A0, data_oe;
    logic [7:0] rd_data, vector, data_out;

    typedef struct packed {
        logic [1:0] kind;
        logic       a0;
        logic [7:0] data;
        logic       oe;
        logic [7:0] lowLen;
    } busEv_t;

    localparam logic [1:0] EV_WR = 2'd1;
    localparam logic [1:0] EV_RD = 2'd2;
    localparam logic [1:0] EV_IA = 2'd3;

    busEv_t expQ[$];
    busEv_t obsQ[$];
    int     gapQ[$];
    int     checks = 0;
    int     errors = 0;
    int     busyCnt = 0;
    int     oeCnt = 0;

    pic_bus_master dut (
        .clk(clk), .rst(rst), .init_req(init_req), .icw1(icw1), .icw2(icw2),
        .icw3(icw3), .icw4(icw4), .ocw_req(ocw_req), .ocw_a0(ocw_a0),
        .ocw_data(ocw_data), .rd_req(rd_req), .rd_a0(rd_a0), .int_in(int_in),
        .busy(busy), .done(done), .rd_data(rd_data), .vector_valid(vector_valid),
        .vector(vector), .WR_n(WR_n), .RD_n(RD_n), .INTA_n(INTA_n), .A0(A0),
        .data_out(data_out), .data_oe(data_oe), .data_in(data_in)
    );

    always #5 clk = ~clk;

    // Strobe monitor: one event per low pulse, pushed when the strobe rises.
    busEv_t wrEv, rdEv;
    int     wrCnt = 0, rdCnt = 0, iaCnt = 0, iaGap = 0;
    always @(negedge clk) begin
        if (rst) begin
            wrCnt = 0; rdCnt = 0; iaCnt = 0; iaGap = 0;
        end else begin
            if (busy) busyCnt++;
            if (data_oe) oeCnt++;
            if (!WR_n) begin
                if (wrCnt == 0) begin
                    wrEv.a0 = A0; wrEv.data = data_out; wrEv.oe = data_oe;
                end
                wrCnt++;
            end else if (wrCnt != 0) begin
                wrEv.kind = EV_WR; wrEv.lowLen = 8'(wrCnt);
                obsQ.push_back(wrEv); wrCnt = 0;
            end
            if (!RD_n) begin
                if (rdCnt == 0) begin
                    rdEv.a0 = A0; rdEv.data = 8'h00; rdEv.oe = data_oe;
                end
                rdCnt++;
            end else if (rdCnt != 0) begin
                rdEv.kind = EV_RD; rdEv.lowLen = 8'(rdCnt);
                obsQ.push_back(rdEv); rdCnt = 0;
            end
            if (!INTA_n) begin
                if (iaCnt == 0) begin
                    gapQ.push_back(iaGap); iaGap = 0;
                end
                iaCnt++;
            end else begin
                if (iaCnt != 0) begin
                    obsQ.push_back({EV_IA, 1'b0, 8'h00, 1'b0, 8'(iaCnt)});
                    iaCnt = 0;
                end
                iaGap++;
            end
        end
    end

    function automatic busEv_t mkEv(logic [1:0] k, logic a, logic [7:0] d, logic o,
                                    logic [7:0] l);
        busEv_t e;
        e.kind = k; e.a0 = a; e.data = d; e.oe = o; e.lowLen = l;
        return e;
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic flushQ;
        expQ.delete(); obsQ.delete(); gapQ.delete();
    endtask

    task automatic waitEnd(output int n, output bit timedOut);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(done || vector_valid) && n < 300);
        timedOut = !(done || vector_valid);
    endtask

    task automatic test_reset;
        rst = 1'b1; init_req = 0; ocw_req = 0; rd_req = 0; int_in = 0;
        icw1 = 0; icw2 = 0; icw3 = 0; icw4 = 0; ocw_a0 = 0; rd_a0 = 0;
        ocw_data = 0; data_in = 0;
        repeat (3) tick;
        @(negedge clk);
        checks++;
        if ({WR_n, RD_n, INTA_n, A0, data_oe, busy, done, vector_valid} !== 8'b1110_0000) begin
            errors++;
            $display("[TB] FAIL reset_ctrl got %b want 11100000",
                     {WR_n, RD_n, INTA_n, A0, data_oe, busy, done, vector_valid});
        end
        checks++;
        if ({data_out, rd_data, vector} !== 24'h0) begin
            errors++;
            $display("[TB] FAIL reset_data got %h want 000000", {data_out, rd_data, vector});
        end
        tick;
        rst = 1'b0;
        tick;
    endtask

    task automatic test_init_three;
        int n; bit timedOut; busEv_t e, o;
        flushQ;
        icw1 = 8'h13; icw2 = 8'h40; icw3 = 8'hAA; icw4 = 8'h01;
        expQ.push_back(mkEv(EV_WR, 1'b0, 8'h13, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h40, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h01, 1'b1, 8'd2));
        init_req = 1'b1; busyCnt = 0; oeCnt = 0;
        tick;
        init_req = 1'b0;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || n != 13 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init3_done got cycle %0d busy %b want cycle 13 busy 0", n, busy);
        end
        checks++;
        if (busyCnt != 12 || oeCnt != 12) begin
            errors++;
            $display("[TB] FAIL init3_busy got busy %0d oe %0d want 12 12", busyCnt, oeCnt);
        end
        tick;
        while (expQ.size() != 0) begin
            e = expQ.pop_front(); checks++;
            o = (obsQ.size() != 0) ? obsQ.pop_front() : '0;
            if (o !== e) begin
                errors++; $display("[TB] FAIL init3_bus got %h want %h", o, e);
            end
        end
        checks++;
        if (obsQ.size() != 0) begin
            errors++; $display("[TB] FAIL init3_extra got %0d events want 0", obsQ.size());
        end
    endtask

    task automatic test_init_ignore_ocw;
        int n; bit timedOut; busEv_t e, o;
        flushQ;
        icw1 = 8'h01; icw2 = 8'h48; icw3 = 8'h04; icw4 = 8'h03;
        expQ.push_back(mkEv(EV_WR, 1'b0, 8'h11, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h48, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h04, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h03, 1'b1, 8'd2));
        init_req = 1'b1; busyCnt = 0; oeCnt = 0;
        tick;
        init_req = 1'b0;
        tick;
        ocw_a0 = 1'b0; ocw_data = 8'hC3; ocw_req = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b1) begin
            errors++; $display("[TB] FAIL init4_busy_mid got %b want 1", busy);
        end
        tick;
        ocw_req = 1'b0;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || busyCnt != 16 || oeCnt != 16) begin
            errors++;
            $display("[TB] FAIL init4_len got busy %0d oe %0d want 16 16", busyCnt, oeCnt);
        end
        tick;
        while (expQ.size() != 0) begin
            e = expQ.pop_front(); checks++;
            o = (obsQ.size() != 0) ? obsQ.pop_front() : '0;
            if (o !== e) begin
                errors++; $display("[TB] FAIL init4_bus got %h want %h", o, e);
            end
        end
        repeat (10) tick;
        @(negedge clk);
        checks++;
        if (obsQ.size() != 0 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL init4_ocw_ignored got %0d events busy %b want 0 0",
                     obsQ.size(), busy);
        end
        tick;
    endtask

    task automatic test_ocw;
        int n; bit timedOut; busEv_t e, o;
        flushQ;
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h20, 1'b1, 8'd2));
        ocw_a0 = 1'b1; ocw_data = 8'h20; ocw_req = 1'b1; oeCnt = 0;
        tick;
        ocw_req = 1'b0;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || n != 5 || oeCnt != 4) begin
            errors++; $display("[TB] FAIL ocw_done got cycle %0d oe %0d want 5 4", n, oeCnt);
        end
        tick;
        while (expQ.size() != 0) begin
            e = expQ.pop_front(); checks++;
            o = (obsQ.size() != 0) ? obsQ.pop_front() : '0;
            if (o !== e) begin
                errors++; $display("[TB] FAIL ocw_bus got %h want %h", o, e);
            end
        end
    endtask

    task automatic test_read;
        int n; bit timedOut; busEv_t e, o;
        flushQ;
        expQ.push_back(mkEv(EV_RD, 1'b0, 8'h00, 1'b0, 8'd2));
        data_in = 8'h00; rd_a0 = 1'b0; rd_req = 1'b1; busyCnt = 0; oeCnt = 0;
        tick;
        rd_req = 1'b0;
        n = 0;
        do begin
            @(negedge clk); n++;
        end while (RD_n !== 1'b0 && n < 20);
        data_in = 8'h5A;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || n != 3 || rd_data !== 8'h5A) begin
            errors++;
            $display("[TB] FAIL read_data got %h at cycle %0d want 5a at cycle 3", rd_data, n);
        end
        checks++;
        if (busyCnt != 4 || oeCnt != 0) begin
            errors++;
            $display("[TB] FAIL read_busy got busy %0d oe %0d want 4 0", busyCnt, oeCnt);
        end
        tick;
        while (expQ.size() != 0) begin
            e = expQ.pop_front(); checks++;
            o = (obsQ.size() != 0) ? obsQ.pop_front() : '0;
            if (o !== e) begin
                errors++; $display("[TB] FAIL read_bus got %h want %h", o, e);
            end
        end
        data_in = 8'h00;
    endtask

    task automatic test_inta;
        int n; bit timedOut; busEv_t e, o;
        flushQ;
        expQ.push_back(mkEv(EV_IA, 1'b0, 8'h00, 1'b0, 8'd2));
        expQ.push_back(mkEv(EV_IA, 1'b0, 8'h00, 1'b0, 8'd2));
        data_in = 8'hEE; int_in = 1'b1; busyCnt = 0;
        n = 0;
        do begin @(negedge clk); n++; end while (INTA_n !== 1'b0 && n < 20);
        do begin @(negedge clk); n++; end while (INTA_n !== 1'b1 && n < 40);
        do begin @(negedge clk); n++; end while (INTA_n !== 1'b0 && n < 60);
        data_in = 8'h43; int_in = 1'b0;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || n != 2 || vector !== 8'h43 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL inta_vector got %h cycle %0d busy %b want 43 cycle 2 busy 0",
                     vector, n, busy);
        end
        checks++;
        if (busyCnt != 6) begin
            errors++; $display("[TB] FAIL inta_busy got %0d want 6", busyCnt);
        end
        @(negedge clk);
        checks++;
        if (vector_valid !== 1'b0) begin
            errors++; $display("[TB] FAIL inta_vv_pulse got %b want 0", vector_valid);
        end
        while (expQ.size() != 0) begin
            e = expQ.pop_front(); checks++;
            o = (obsQ.size() != 0) ? obsQ.pop_front() : '0;
            if (o !== e) begin
                errors++; $display("[TB] FAIL inta_bus got %h want %h", o, e);
            end
        end
        checks++;
        if (gapQ.size() != 2 || gapQ[gapQ.size() - 1] != 2) begin
            errors++;
            $display("[TB] FAIL inta_gap got %0d pulses last gap %0d want 2 2", gapQ.size(),
                     (gapQ.size() != 0) ? gapQ[gapQ.size() - 1] : -1);
        end
        data_in = 8'h00;
        tick;
    endtask

    task automatic test_priority;
        int n; bit timedOut; busEv_t e, o;
        flushQ;
        icw1 = 8'h02; icw2 = 8'h50;
        expQ.push_back(mkEv(EV_WR, 1'b0, 8'h12, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h50, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_IA, 1'b0, 8'h00, 1'b0, 8'd2));
        expQ.push_back(mkEv(EV_IA, 1'b0, 8'h00, 1'b0, 8'd2));
        data_in = 8'h47; init_req = 1'b1; int_in = 1'b1;
        tick;
        init_req = 1'b0;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || n != 9 || INTA_n !== 1'b1 || done !== 1'b1) begin
            errors++;
            $display("[TB] FAIL prio_init_first got cycle %0d inta %b want cycle 9 inta 1",
                     n, INTA_n);
        end
        @(negedge clk);
        checks++;
        if (INTA_n !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("[TB] FAIL prio_idle_gap got inta %b busy %b want 1 0", INTA_n, busy);
        end
        @(negedge clk);
        checks++;
        if (INTA_n !== 1'b0) begin
            errors++; $display("[TB] FAIL prio_inta_start got %b want 0", INTA_n);
        end
        int_in = 1'b0;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || vector !== 8'h47) begin
            errors++; $display("[TB] FAIL prio_vector got %h want 47", vector);
        end
        tick;
        while (expQ.size() != 0) begin
            e = expQ.pop_front(); checks++;
            o = (obsQ.size() != 0) ? obsQ.pop_front() : '0;
            if (o !== e) begin
                errors++; $display("[TB] FAIL prio_bus got %h want %h", o, e);
            end
        end
        data_in = 8'h00;
    endtask

    task automatic test_reset_mid;
        int n, falls; bit timedOut; logic prevWr; busEv_t e, o;
        flushQ;
        icw1 = 8'h13; icw2 = 8'h40; icw4 = 8'h01;
        init_req = 1'b1;
        tick;
        init_req = 1'b0;
        n = 0; falls = 0; prevWr = 1'b1;
        while (falls < 2 && n < 100) begin
            @(negedge clk); n++;
            if (prevWr && !WR_n) falls++;
            prevWr = WR_n;
        end
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (WR_n !== 1'b1 || busy !== 1'b0 || data_oe !== 1'b0 || falls != 2) begin
            errors++;
            $display("[TB] FAIL rstmid_strobe got wr %b busy %b oe %b falls %0d want 1 0 0 2",
                     WR_n, busy, data_oe, falls);
        end
        checks++;
        if ({rd_data, vector} !== 16'h0) begin
            errors++; $display("[TB] FAIL rstmid_regs got %h want 0000", {rd_data, vector});
        end
        rst = 1'b0;
        tick;
        flushQ;
        icw1 = 8'h02; icw2 = 8'h60;
        expQ.push_back(mkEv(EV_WR, 1'b0, 8'h12, 1'b1, 8'd2));
        expQ.push_back(mkEv(EV_WR, 1'b1, 8'h60, 1'b1, 8'd2));
        init_req = 1'b1;
        tick;
        init_req = 1'b0;
        waitEnd(n, timedOut);
        checks++;
        if (timedOut || n != 9) begin
            errors++; $display("[TB] FAIL rstmid_fresh got cycle %0d want 9", n);
        end
        tick;
        while (expQ.size() != 0) begin
            e = expQ.pop_front(); checks++;
            o = (obsQ.size() != 0) ? obsQ.pop_front() : '0;
            if (o !== e) begin
                errors++; $display("[TB] FAIL rstmid_bus got %h want %h", o, e);
            end
        end
    endtask

    initial begin
        test_reset;
        test_init_three;
        test_init_ignore_ocw;
        test_ocw;
        test_read;
        test_inta;
        test_priority;
        test_reset_mid;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog got timeout want completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
